// File: rtl/mux_4_1.sv
// Four-lane multiplexer with a combinational output and an enable-gated registered
// output. The registered path also tracks the captured select, select changes and data validity.
module mux_4_1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] I,
  input  logic [1:0]         S,
  input  logic               en,
  output logic [WIDTH-1:0]   Y,
  output logic [WIDTH-1:0]   Y_comb,
  output logic [1:0]         sel_q,
  output logic               sel_chg,
  output logic               valid
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       sel_d;
  logic             chg_q, chg_d;
  logic             valid_q, valid_d;

  always_comb begin
    Y_comb = I[0 +: WIDTH];
    case (S)
      2'b00: Y_comb = I[0*WIDTH +: WIDTH];
      2'b01: Y_comb = I[1*WIDTH +: WIDTH];
      2'b10: Y_comb = I[2*WIDTH +: WIDTH];
      2'b11: Y_comb = I[3*WIDTH +: WIDTH];
    endcase
  end

  always_comb begin
    y_d     = y_q;
    sel_d   = sel_q;
    chg_d   = 1'b0;
    valid_d = valid_q;
    if (en) begin
      y_d     = Y_comb;
      sel_d   = S;
      // The first capture after reset has no previous select to compare against.
      chg_d   = valid_q && (S != sel_q);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      sel_q   <= 2'b00;
      chg_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      chg_q   <= chg_d;
      valid_q <= valid_d;
    end
  end

  assign Y       = y_q;
  assign sel_chg = chg_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_mux_4_1.sv
// Bench for mux_4_1: directed scenarios with literal expectations, then random traffic
// compared every cycle against a capture-history model.
module tb_mux_4_1;
  localparam int W = 1;

  logic           clk;
  logic           rst_n;
  logic [4*W-1:0] I;
  logic [1:0]     S;
  logic           en;
  logic [W-1:0]   Y;
  logic [W-1:0]   Y_comb;
  logic [1:0]     sel_q;
  logic           sel_chg;
  logic           valid;

  int checks = 0;
  int errors = 0;

  mux_4_1 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .I(I), .S(S), .en(en),
    .Y(Y), .Y_comb(Y_comb), .sel_q(sel_q), .sel_chg(sel_chg), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: number of captures since reset, last captured data and select,
  // and whether the most recent edge was a capture that changed the select.
  int          m_captures;
  logic [31:0] m_y;
  logic [1:0]  m_sel;
  logic        m_chg;
  bit          m_ok = 0;

  function automatic logic [31:0] lane_of(logic [4*W-1:0] data, logic [1:0] s);
    logic [31:0] d;
    d = 32'(data);
    return (d >> (int'(s) * W)) & ((32'd1 << W) - 1);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_captures = 0;
      m_y        = 0;
      m_sel      = 2'b00;
      m_chg      = 1'b0;
    end else if (en) begin
      m_chg      = (m_captures > 0) && (S != m_sel);
      m_y        = lane_of(I, S);
      m_sel      = S;
      m_captures = m_captures + 1;
    end else begin
      m_chg = 1'b0;
    end
    m_ok = 1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmp_y",       32'(Y),       m_y);
      chk("cmp_sel_q",   32'(sel_q),   32'(m_sel));
      chk("cmp_sel_chg", 32'(sel_chg), 32'(m_chg));
      chk("cmp_valid",   32'(valid),   32'(m_captures > 0));
      chk("cmp_y_comb",  32'(Y_comb),  lane_of(I, S));
    end
  end

  // Inputs are driven 1 time unit after a rising edge; tick returns 1 unit after the next edge.
  task automatic drive(logic r, logic e, logic [4*W-1:0] i, logic [1:0] s);
    rst_n = r; en = e; I = i; S = s;
  endtask

  task automatic tick(logic r, logic e, logic [4*W-1:0] i, logic [1:0] s);
    drive(r, e, i, s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'b0000, 2'b00);
    @(posedge clk);
    #1;

    // Reset held for two edges
    tick(1'b0, 1'b0, 4'b0000, 2'b00);
    chk("rst_y",       32'(Y),       0);
    chk("rst_valid",   32'(valid),   0);
    chk("rst_sel_chg", 32'(sel_chg), 0);
    chk("rst_y_comb",  32'(Y_comb),  0);

    // First capture, lane 0 of 1101
    drive(1'b1, 1'b1, 4'b1101, 2'b00);
    #1 chk("cap0_y_comb", 32'(Y_comb), 1);
    @(posedge clk); #1;
    chk("cap0_y",       32'(Y),       1);
    chk("cap0_valid",   32'(valid),   1);
    chk("cap0_sel_chg", 32'(sel_chg), 0);

    // Select change to lane 2
    drive(1'b1, 1'b1, 4'b1101, 2'b10);
    #1 chk("s10_y_comb", 32'(Y_comb), 1);
    @(posedge clk); #1;
    chk("s10_y",       32'(Y),       1);
    chk("s10_sel_q",   32'(sel_q),   2);
    chk("s10_sel_chg", 32'(sel_chg), 1);
    tick(1'b1, 1'b1, 4'b1101, 2'b10);
    chk("s10_chg_drop", 32'(sel_chg), 0);

    // 1001: lane 3 then lane 2
    tick(1'b1, 1'b1, 4'b1001, 2'b11);
    chk("s11_y",       32'(Y),       1);
    chk("s11_sel_chg", 32'(sel_chg), 1);
    drive(1'b1, 1'b1, 4'b1001, 2'b10);
    #1 chk("s10b_y_comb", 32'(Y_comb), 0);
    @(posedge clk); #1;
    chk("s10b_y",       32'(Y),       0);
    chk("s10b_sel_chg", 32'(sel_chg), 1);

    // Hold with en low while Y_comb keeps following I and S
    drive(1'b1, 1'b0, 4'b0110, 2'b01);
    #1 chk("hold_y_comb0", 32'(Y_comb), 1);
    @(posedge clk); #1;
    chk("hold_y",       32'(Y),       0);
    chk("hold_sel_q",   32'(sel_q),   2);
    chk("hold_sel_chg", 32'(sel_chg), 0);
    drive(1'b1, 1'b0, 4'b1000, 2'b11);
    #1 chk("hold_y_comb1", 32'(Y_comb), 1);
    @(posedge clk); #1;
    chk("hold2_y",     32'(Y),     0);
    chk("hold2_sel_q", 32'(sel_q), 2);

    // Reset wins over a simultaneous capture; next capture counts as the first
    tick(1'b0, 1'b1, 4'b1111, 2'b11);
    chk("rstcap_y",     32'(Y),     0);
    chk("rstcap_valid", 32'(valid), 0);
    chk("rstcap_sel_q", 32'(sel_q), 0);
    tick(1'b1, 1'b1, 4'b1111, 2'b11);
    chk("first_y",       32'(Y),       1);
    chk("first_valid",   32'(valid),   1);
    chk("first_sel_chg", 32'(sel_chg), 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      tick(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7),
           (4*W)'($urandom), 2'($urandom));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4_1.md
MUX_4_1 -- requirements
Module: mux_4_1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, giving the width of each data lane and of the outputs Y and Y_comb.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port I, input, 4*WIDTH bits: four data lanes; lane k is I[k*WIDTH +: WIDTH].
REQ-005 The block SHALL have port S, input, 2 bits: lane select, value k selects lane k.
REQ-006 The block SHALL have port en, input, 1 bit: capture enable for the registered path.
REQ-007 The block SHALL have port Y, output, WIDTH bits: registered mux output.
REQ-008 The block SHALL have port Y_comb, output, WIDTH bits: combinational mux output.
REQ-009 The block SHALL have port sel_q, output, 2 bits: select value captured alongside Y.
REQ-010 The block SHALL have port sel_chg, output, 1 bit: one-cycle pulse when the captured select differs from the previous capture.
REQ-011 The block SHALL have port valid, output, 1 bit: high once Y holds data captured since the last reset.

Function
REQ-012 The block SHALL drive Y_comb equal to lane S of I, with zero-cycle latency and no dependence on clk, rst_n or en.
REQ-013 The block SHALL define all four S codes (00, 01, 10, 11), so no X or default case exists.
REQ-014 On a rising edge with rst_n=1 and en=1, the block SHALL load Y with lane S of I and load sel_q with S, giving one-cycle latency from I/S to Y.
REQ-015 On a rising edge with rst_n=1 and en=0, the block SHALL hold Y and sel_q unchanged.
REQ-016 On an enabled capture, the block SHALL set sel_chg to 1 when S differs from the current sel_q and valid=1, and to 0 otherwise.
REQ-017 On a non-enabled edge, the block SHALL set sel_chg to 0, so sel_chg is never high for two cycles without two enabled captures.
REQ-018 The block SHALL set valid to 1 on the first enabled capture after reset; valid SHALL then stay 1 until the next reset.
REQ-019 The block SHALL capture into Y the value of I present at the edge when I and S change in the same cycle as an enabled edge.
REQ-020 The first capture after reset SHALL never assert sel_chg, even when S differs from the reset value 00 of sel_q.

Reset
REQ-021 On a rising edge with rst_n=0, the block SHALL set Y=0, sel_q=2'b00, sel_chg=0 and valid=0, regardless of en.
REQ-022 Y_comb SHALL stay purely combinational and SHALL NOT be affected by reset.
REQ-023 A reset asserted mid-operation SHALL take priority over a simultaneous enabled capture; the first enabled edge after rst_n returns to 1 SHALL behave as the first capture.

Verification
REQ-024 The bench SHALL check, with WIDTH=1, rst_n low for 2 edges and I=4'b0000, S=00: Y=0, valid=0, sel_chg=0 and Y_comb=0.
REQ-025 The bench SHALL check, with rst_n=1, en=1, I=4'b1101, S=00: Y_comb=1 immediately, and after one edge Y=1, valid=1, sel_chg=0.
REQ-026 The bench SHALL check, with I=4'b1101 and S changed to 10 under en=1: Y_comb=1, and after the edge Y=1, sel_q=10, sel_chg=1 for exactly one cycle.
REQ-027 The bench SHALL check I=4'b1001, S=11 -> Y=1, then S=10 -> Y_comb=0 and Y=0 after one edge, with sel_chg pulsing on each change.
REQ-028 The bench SHALL check that with en=0, changing I and S leaves Y and sel_q held while Y_comb tracks I and S, and sel_chg=0.
REQ-029 The bench SHALL check that asserting rst_n=0 together with en=1 on the same edge gives Y=0 and valid=0, and that the next enabled capture gives sel_chg=0.
